// File: rtl/prbs32_checker_pkg.sv
// Shared encodings and helpers for the PRBS32 receive checker.
// Optional word counter: PRBS32_CHK_WORDCNT_EN (consumed by the top).
package prbs32_checker_pkg;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } chk_state_e;

  // x^32 + x^22 + x^2 + x^1 + 1 as feedback taps on bits 31,21,1,0
  localparam logic [31:0] PRBS32_TAPS = 32'h8020_0003;

  localparam int POP_W = 6;

  function automatic logic [POP_W-1:0] popcount32(
    input logic [31:0] v
  );
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prbs32_checker_step.sv
// PRBS32 word step: 32 Fibonacci shifts, oldest bit in MSB,
// newest feedback bit enters at bit 0.
module prbs32_step
  import prbs32_checker_pkg::*;
(
  input  logic [31:0] i_state,
  output logic [31:0] o_state
);

  logic [31:0] w_s;

  always_comb begin
    w_s = i_state;
    for (int i = 0; i < 32; i++) begin
      w_s = {w_s[30:0], ^(w_s & PRBS32_TAPS)};
    end
    o_state = w_s;
  end

endmodule

// File: rtl/prbs32_checker.sv
// PRBS32 checker: self-seeds, verifies lock, flywheels, counts bit errors.
// Define PRBS32_CHK_WORDCNT_EN to build the locked-word counter.
module prbs32_checker
  import prbs32_checker_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W      = 32
) (
  input  logic             Clk,
  input  logic             ARst,
  input  logic             Enable,
  input  logic [31:0]      Data,
  input  logic             Clear,
  output logic             Locked,
  output logic             ErrWord,
  output logic [ERR_W-1:0] ErrCount,
  output logic [31:0]      WordCount
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam int SW = ERR_W + POP_W;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  chk_state_e       r_state;
  chk_state_e       w_state_nx;
  logic [31:0]      r_expected;
  logic [31:0]      w_exp_nx;
  logic [MW-1:0]    r_match;
  logic [MW-1:0]    w_match_nx;
  logic [BW-1:0]    r_bad;
  logic [BW-1:0]    w_bad_nx;
  logic             r_locked;
  logic             r_err_word;
  logic             w_err_word_nx;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ERR_W-1:0] w_err_cnt_nx;
  logic [SW-1:0]    w_sum;
  logic [POP_W-1:0] w_pop;
  logic [POP_W-1:0] w_diff_pop;
  logic [31:0]      w_step_data;
  logic [31:0]      w_step_exp;

  prbs32_step u_step_data (
    .i_state (Data),
    .o_state (w_step_data)
  );

  prbs32_step u_step_exp (
    .i_state (r_expected),
    .o_state (w_step_exp)
  );

  assign w_diff_pop = popcount32(Data ^ r_expected);

  always_comb begin
    w_state_nx    = r_state;
    w_exp_nx      = r_expected;
    w_match_nx    = r_match;
    w_bad_nx      = r_bad;
    w_err_word_nx = 1'b0;
    w_pop         = '0;
    if (Enable) begin
      unique case (r_state)
        S_SEARCH: begin
          if (Data != '0) begin
            w_exp_nx   = w_step_data;
            w_match_nx = '0;
            w_state_nx = S_VERIFY;
          end
        end
        S_VERIFY: begin
          w_exp_nx = w_step_data;
          if (Data == r_expected) begin
            w_match_nx = r_match + 1'b1;
            if (w_match_nx == MW'(LOCK_CNT)) begin
              w_state_nx = S_LOCKED;
              w_bad_nx   = '0;
            end
          end else begin
            w_match_nx = '0;
            if (Data == '0) begin
              w_state_nx = S_SEARCH;
            end
          end
        end
        S_LOCKED: begin
          // flywheel: prediction never follows the received data here
          w_exp_nx = w_step_exp;
          w_pop    = w_diff_pop;
          if (w_diff_pop != '0) begin
            w_err_word_nx = 1'b1;
            w_bad_nx      = r_bad + 1'b1;
            if (w_bad_nx == BW'(UNLOCK_CNT)) begin
              w_state_nx = S_SEARCH;
              w_bad_nx   = '0;
            end
          end else begin
            w_bad_nx = '0;
          end
        end
        default: begin
          w_state_nx = S_SEARCH;
        end
      endcase
    end
  end

  always_comb begin
    w_sum = SW'(r_err_cnt) + SW'(w_pop);
    if (w_sum > SW'(ERR_MAX)) begin
      w_err_cnt_nx = ERR_MAX;
    end else begin
      w_err_cnt_nx = w_sum[ERR_W-1:0];
    end
  end

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      r_state    <= S_SEARCH;
      r_expected <= '0;
      r_match    <= '0;
      r_bad      <= '0;
      r_locked   <= 1'b0;
      r_err_word <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_expected <= w_exp_nx;
      r_match    <= w_match_nx;
      r_bad      <= w_bad_nx;
      r_locked   <= (w_state_nx == S_LOCKED);
      r_err_word <= w_err_word_nx;
      r_err_cnt  <= Clear ? '0 : w_err_cnt_nx;
    end
  end

  assign Locked   = r_locked;
  assign ErrWord  = r_err_word;
  assign ErrCount = r_err_cnt;

`ifdef PRBS32_CHK_WORDCNT_EN
  logic [31:0] r_word_cnt;
  logic        w_cnt_word;

  assign w_cnt_word = Enable && (r_state == S_LOCKED);

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      r_word_cnt <= '0;
    end else if (Clear) begin
      r_word_cnt <= '0;
    end else if (w_cnt_word && (r_word_cnt != '1)) begin
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  assign WordCount = r_word_cnt;
`else
  assign WordCount = '0;
`endif

endmodule
